// File: rtl/fft_peak_index_if.sv
// Avalon-ST sink bundle carrying complex FFT bins into the peak finder.
interface fft_peak_index_if #(
  parameter int DATA_W = 16
);
  logic                     sink_valid;
  logic                     sink_ready;
  logic                     sink_sop;
  logic                     sink_eop;
  logic signed [DATA_W-1:0] sink_real;
  logic signed [DATA_W-1:0] sink_imag;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
    input  sink_ready
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
    output sink_ready
  );
endinterface

// File: rtl/fft_peak_index.sv
// FFT peak finder: per frame, reports the bin with the largest re^2+im^2
// inside the search window, three cycles after the frame's last beat.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | between frames; only a sop beat is accepted
// ST_IN_FRAME | frame open; every valid beat advances the bin counter
module fft_peak_index #(
  parameter int DATA_W        = 16,
  parameter int FFT_LEN       = 256,
  parameter int IDX_W         = 8,
  parameter bit SKIP_DC       = 1'b1,
  parameter bit HALF_SPECTRUM = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  fft_peak_index_if.slave       sink,
  output logic [7:0]            max_index_byte_o,
  output logic [2*DATA_W-1:0]   max_mag_o,
  output logic                  index_valid_o,
  output logic                  frame_err_o
);

  localparam int               MAG_W    = 2 * DATA_W;
  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(FFT_LEN - 1);
  localparam logic [IDX_W-1:0] HALF_BIN = IDX_W'(FFT_LEN / 2);

  typedef enum logic {ST_IDLE, ST_IN_FRAME} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   bin_q;
  logic               ovf_q;

  // Stage 1: squares plus per-beat side-band
  logic               s1_v_q, s1_err_q, s1_sop_q, s1_eop_q, s1_win_q, s1_len_ok_q;
  logic [IDX_W-1:0]   s1_bin_q;
  logic [MAG_W-1:0]   re_sq_q, im_sq_q;

  // Stage 2: magnitude
  logic               s2_v_q, s2_err_q, s2_sop_q, s2_eop_q, s2_win_q, s2_len_ok_q;
  logic [IDX_W-1:0]   s2_bin_q;
  logic [MAG_W-1:0]   mag_q;

  // Stage 3: running best and published results
  logic               have_q, have_d;
  logic [MAG_W-1:0]   best_mag_q, best_mag_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [7:0]         max_idx_q;
  logic [MAG_W-1:0]   max_mag_q;
  logic               index_valid_q, frame_err_q;

  logic               beat_accept;
  logic [IDX_W-1:0]   beat_bin;
  logic               beat_ovf;
  logic               beat_win;
  logic               beat_len_ok;
  logic signed [MAG_W-1:0] re_ext, im_ext;
  logic               s3_first, s3_take, s3_close;

  assign sink.sink_ready = 1'b1;

  // A sop beat always (re)starts a frame; other beats only count inside one.
  // Past the last bin the counter sticks and the overflow flag latches.
  assign beat_accept = sink.sink_sop | (state_q == ST_IN_FRAME);
  assign beat_bin    = sink.sink_sop ? '0 :
                       ((bin_q == LAST_BIN) ? bin_q : bin_q + 1'b1);
  assign beat_ovf    = sink.sink_sop ? 1'b0 : (ovf_q | (bin_q == LAST_BIN));
  assign beat_win    = !(SKIP_DC && (beat_bin == '0)) &&
                       !(HALF_SPECTRUM && (beat_bin >= HALF_BIN));
  assign beat_len_ok = (beat_bin == LAST_BIN) && !beat_ovf;

  assign re_ext = MAG_W'(sink.sink_real);
  assign im_ext = MAG_W'(sink.sink_imag);

  // Frame FSM and stage 1 capture; an idle valid-low cycle changes nothing.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      bin_q       <= '0;
      ovf_q       <= 1'b0;
      s1_v_q      <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_sop_q    <= 1'b0;
      s1_eop_q    <= 1'b0;
      s1_win_q    <= 1'b0;
      s1_len_ok_q <= 1'b0;
      s1_bin_q    <= '0;
      re_sq_q     <= '0;
      im_sq_q     <= '0;
    end else begin
      s1_v_q   <= 1'b0;
      s1_err_q <= 1'b0;
      if (sink.sink_valid) begin
        if (beat_accept) begin
          case (state_q)
            ST_IDLE:     state_q <= sink.sink_eop ? ST_IDLE : ST_IN_FRAME;
            ST_IN_FRAME: state_q <= sink.sink_eop ? ST_IDLE : ST_IN_FRAME;
            default:     state_q <= ST_IDLE;
          endcase
          bin_q       <= beat_bin;
          ovf_q       <= beat_ovf;
          s1_v_q      <= 1'b1;
          s1_err_q    <= sink.sink_sop && (state_q == ST_IN_FRAME);
          s1_sop_q    <= sink.sink_sop;
          s1_eop_q    <= sink.sink_eop;
          s1_win_q    <= beat_win;
          s1_len_ok_q <= beat_len_ok;
          s1_bin_q    <= beat_bin;
          re_sq_q     <= re_ext * re_ext;
          im_sq_q     <= im_ext * im_ext;
        end else begin
          // stray beat outside a frame: dropped, flagged only if it closes
          s1_err_q <= sink.sink_eop;
        end
      end
    end
  end

  // Stage 2: sum of squares; at most 2^(MAG_W-1), so no carry out is lost.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s2_v_q      <= 1'b0;
      s2_err_q    <= 1'b0;
      s2_sop_q    <= 1'b0;
      s2_eop_q    <= 1'b0;
      s2_win_q    <= 1'b0;
      s2_len_ok_q <= 1'b0;
      s2_bin_q    <= '0;
      mag_q       <= '0;
    end else begin
      s2_v_q      <= s1_v_q;
      s2_err_q    <= s1_err_q;
      s2_sop_q    <= s1_sop_q;
      s2_eop_q    <= s1_eop_q;
      s2_win_q    <= s1_win_q;
      s2_len_ok_q <= s1_len_ok_q;
      s2_bin_q    <= s1_bin_q;
      mag_q       <= re_sq_q + im_sq_q;
    end
  end

  // A sop beat forgets the previous frame's best, which keeps back-to-back
  // frames independent without any FSM involvement.
  assign s3_first = s2_sop_q | ~have_q;
  assign s3_take  = s2_v_q & s2_win_q & (s3_first | (mag_q > best_mag_q));
  assign s3_close = s2_v_q & s2_eop_q;

  // Stage 3 next-state for the running best; ties keep the lower bin.
  always_comb begin
    best_mag_d = best_mag_q;
    best_idx_d = best_idx_q;
    have_d     = have_q & ~(s2_v_q & s2_sop_q);
    if (s3_take) begin
      best_mag_d = mag_q;
      best_idx_d = s2_bin_q;
      have_d     = 1'b1;
    end
  end

  // Stage 3 registers: running best, published result and status pulses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      have_q        <= 1'b0;
      best_mag_q    <= '0;
      best_idx_q    <= '0;
      max_idx_q     <= '0;
      max_mag_q     <= '0;
      index_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      have_q        <= have_d;
      best_mag_q    <= best_mag_d;
      best_idx_q    <= best_idx_d;
      index_valid_q <= s3_close & s2_len_ok_q;
      frame_err_q   <= s2_err_q | (s3_close & ~s2_len_ok_q);
      if (s3_close && s2_len_ok_q) begin
        max_idx_q <= have_d ? 8'(best_idx_d) : 8'd0;
        max_mag_q <= have_d ? best_mag_d : '0;
      end
    end
  end

  assign max_index_byte_o = max_idx_q;
  assign max_mag_o        = max_mag_q;
  assign index_valid_o    = index_valid_q;
  assign frame_err_o      = frame_err_q;

endmodule

// File: doc/fft_peak_index.md
Name: fft_peak_index

Overview:
- Sits directly upstream of the 8-bit max-index output conduit.
- Consumes the FFT core's Avalon-ST output stream (complex bins with sop/eop).
- Computes |X[k]|² for each bin and finds the bin with the largest magnitude inside the search window.
- Publishes that bin index as a byte once per frame, with a one-cycle valid pulse and the winning magnitude.

Parameters:
DATA_W, 16, signed width of each real/imag component
FFT_LEN, 256, bins per frame; power of two, 2..256
IDX_W, 8, bin counter width = log2(FFT_LEN)
SKIP_DC, 1, 1 = bin 0 excluded from search
HALF_SPECTRUM, 1, 1 = only bins 0..FFT_LEN/2-1 searched

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sink_valid  in  1  beat qualifier
sink_ready  out  1  constant 1; block never backpressures
sink_sop  in  1  first bin of frame
sink_eop  in  1  last bin of frame
sink_real  in  DATA_W  signed real part
sink_imag  in  DATA_W  signed imaginary part
max_index_byte  out  8  winning bin index, zero-extended from IDX_W
max_mag  out  2*DATA_W  winning re²+im², unsigned
index_valid  out  1  one-cycle pulse when outputs update
frame_err  out  1  one-cycle pulse on malformed frame

Behaviour:
- Reset: synchronous, active-high on clk.
  - Outputs: max_index_byte=0, max_mag=0, index_valid=0, frame_err=0.
  - FSM to IDLE; pipeline valids cleared; running best cleared.
  - Reset mid-frame discards the partial frame; no pulse is produced.
- FSM: IDLE, IN_FRAME.
  - IDLE + valid & sop: start frame, bin=0, go IN_FRAME. If eop is also set, treat as a one-beat frame (see length check).
  - IDLE + valid & !sop: beat dropped. If eop is set, frame_err pulses.
  - IN_FRAME + valid: bin increments; it saturates at FFT_LEN-1, with an overflow flag set if more beats arrive.
  - IN_FRAME + valid & sop: frame_err pulses; frame restarts at bin 0 with this beat.
  - IN_FRAME + valid & eop: frame closes, go IDLE.
  - sink_valid low: all state holds; gaps allowed anywhere.
- Pipeline (per accepted beat):
  - S1: register re², im² (signed×signed, 2*DATA_W bits each).
  - S2: sum, unsigned 2*DATA_W bits. Max value 2^(2*DATA_W-1) cannot overflow; (-32768,-32768) gives 0x80000000.
  - S3: compare against running best.
  - bin, sop, eop and in-window flags are delayed alongside the data.
- Search window:
  - bin eligible if !(SKIP_DC && bin==0) && !(HALF_SPECTRUM && bin>=FFT_LEN/2).
  - First eligible bin of a frame always loads the best (even if magnitude is 0).
  - Later bins replace the best only if strictly greater, so ties go to the lowest index.
- Frame close (eop at S3):
  - Valid frame means no overflow and final bin == FFT_LEN-1. Then max_index_byte and max_mag load the best, and index_valid pulses.
  - Latency: eop accepted in cycle T gives index_valid high in cycle T+3.
  - Invalid length: frame_err pulses at T+3; outputs hold their previous values; no index_valid.
- Outputs hold between updates.
- Back-to-back frames (eop at T, sop at T+1) are fully supported with no dead cycles. The running best is reset per frame in the pipeline, not at the FSM.

Test Plan:
1. Reset held 3 cycles, then 10 idle cycles -> max_index_byte=0, max_mag=0, index_valid=0, frame_err=0, sink_ready=1.
2. 256-bin frame, bin 37 = (1000, 0), all others 0, eop at cycle T -> index_valid at T+3, max_index_byte=37, max_mag=1000000.
3. Bins 10 and 20 both (300, -400), rest 0 -> max_index_byte=10, max_mag=250000. Bin 5 = (-32768, -32768) only -> max_index_byte=5, max_mag=0x80000000.
4. Bin 0 = (20000, 0), bin 200 = (30000, 0), bin 5 = (100, 0) -> max_index_byte=5 (DC and upper half excluded); same stimulus with SKIP_DC=0, HALF_SPECTRUM=0 -> 200.
5. eop at beat 100; then a 300-beat frame; then a stray eop in IDLE -> frame_err pulses 3 times; no index_valid; outputs keep the last good values.
6. Two back-to-back frames with random valid gaps, peaks at bins 3 and 90; reset asserted mid-way through a third frame -> two index_valid pulses (3, then 90); after reset all outputs 0, and the next clean frame reports correctly.
